fifo_rd_drain: RTL and testbench

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

---
 rtl/fifo_rd_drain.sv | 156 +++++++++++++++
 tb/tb_fifo_rd_drain.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: drains a fixed-length burst from the read side of a FIFO
// into a 2-entry skid buffer that feeds a valid/ready stream.
//
// Ports
//   rclk, rrst          read-domain clock, asynchronous active-high reset
//   start, burst_len    burst request (sampled in IDLE) and its word count
//   rempty, rdata       FIFO empty flag and head word
//   rinc                FIFO pop strobe (combinational)
//   m_valid, m_ready    output stream handshake
//   m_data              oldest word held in the skid buffer
//   busy, done          burst in progress / one-cycle completion pulse
//   rd_total            16-bit wrapping count of words popped since reset
module fifo_rd_drain #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned LSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             start,
  input  logic [LSIZE-1:0] burst_len,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      rd_total
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned TOT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LSIZE-1:0]   remaining_q, remaining_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [DSIZE-1:0]   buf0_q, buf0_d;   // head (oldest) entry
  logic [DSIZE-1:0]   buf1_q, buf1_d;   // second entry
  logic [TOT_W-1:0]   rd_total_q, rd_total_d;

  logic push;
  logic pop;

  // Output decode straight from registers
  assign m_valid  = (occ_q != OCC_W'(0));
  assign m_data   = buf0_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rd_total = rd_total_q;

  // A full buffer may still accept a word when the head leaves this edge
  assign pop  = m_valid & m_ready;
  assign rinc = (state_q == READ) & ~rempty & (remaining_q != LSIZE'(0)) &
                ((occ_q != OCC_W'(2)) | pop);
  assign push = rinc;

  // Next-state: skid buffer, counters, FSM
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    occ_d       = occ_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    rd_total_d  = rd_total_q;

    unique case (occ_q)
      OCC_W'(0): begin
        if (push) begin
          buf0_d = rdata;
          occ_d  = OCC_W'(1);
        end
      end
      OCC_W'(1): begin
        if (push && pop) begin
          buf0_d = rdata;
        end else if (push) begin
          buf1_d = rdata;
          occ_d  = OCC_W'(2);
        end else if (pop) begin
          occ_d  = OCC_W'(0);
        end
      end
      OCC_W'(2): begin
        // push without pop cannot happen here: rinc is gated on pop
        if (pop) begin
          buf0_d = buf1_q;
          if (push) begin
            buf1_d = rdata;
          end else begin
            occ_d  = OCC_W'(1);
          end
        end
      end
      default: begin
        occ_d = OCC_W'(0);
      end
    endcase

    if (push) begin
      remaining_d = remaining_q - LSIZE'(1);
      rd_total_d  = rd_total_q + TOT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != LSIZE'(0)) begin
            state_d     = READ;
            remaining_d = burst_len;
          end else begin
            state_d     = DONE;
          end
        end
      end
      READ: begin
        // finish once every word is popped and the buffer has drained
        if ((remaining_d == LSIZE'(0)) && (occ_d == OCC_W'(0))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      occ_q       <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      rd_total_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      rd_total_q  <= rd_total_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: self-checking bench for fifo_rd_drain. A queue models the
// FIFO read side; words loaded into it for a burst are also pushed to a
// scoreboard that is compared against every accepted output word.
module tb_fifo_rd_drain;

  logic        rclk;
  logic        rrst;
  logic        start;
  logic [15:0] burst_len;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        busy;
  logic        done;
  logic [15:0] rd_total;

  fifo_rd_drain #(.DSIZE(8), .LSIZE(16)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .start     (start),
    .burst_len (burst_len),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy),
    .done      (done),
    .rd_total  (rd_total)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int          checks;
  int          errors;
  logic [7:0]  fifo_m[$];
  logic [7:0]  sb[$];
  logic        pop_prev;
  logic        force_empty;
  logic        toggle_en;
  logic        inf_src;
  logic        sb_en;
  logic [7:0]  exp_w;
  logic [15:0] exp_total;

  // FIFO model + scoreboard monitor. Inputs are refreshed at the falling
  // edge, outputs are sampled 1 time unit later, ahead of the next rising edge.
  always @(negedge rclk) begin
    if (rrst) begin
      pop_prev = 1'b0;
    end else if (pop_prev) begin
      if (!inf_src && fifo_m.size() > 0) void'(fifo_m.pop_front());
      pop_prev = 1'b0;
    end
    if (toggle_en) force_empty = ~force_empty;
    if (inf_src) begin
      rempty = force_empty;
      rdata  = 8'h00;
    end else begin
      rempty = force_empty || (fifo_m.size() == 0);
      rdata  = (fifo_m.size() > 0) ? fifo_m[0] : 8'h00;
    end
    #1;
    if (!rrst) begin
      if (rinc) begin
        checks++;
        if (rempty) begin
          errors++;
          $display("FAIL underflow: rinc=1 while rempty=1 at %0t", $time);
        end
      end
      pop_prev = rinc;
      if (m_valid && m_ready && sb_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got m_data=%h, expected no word", m_data);
        end else begin
          exp_w = sb.pop_front();
          if (m_data !== exp_w) begin
            errors++;
            $display("FAIL sb_order: got m_data=%h, expected %h", m_data, exp_w);
          end
        end
      end
    end
  end

  task automatic drv();
    @(posedge rclk);
    #1;
  endtask

  task automatic obs();
    @(negedge rclk);
    #2;
  endtask

  task automatic do_start(input logic [15:0] len);
    start     = 1'b1;
    burst_len = len;
    drv();
    start     = 1'b0;
    burst_len = 16'd0;
  endtask

  task automatic load(input logic [7:0] w);
    fifo_m.push_back(w);
    sb.push_back(w);
  endtask

  task automatic wait_done(input int max, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    while (!got && cycles < max) begin
      obs();
      cycles++;
      if (done) got = 1'b1;
      else drv();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, expected within %0d", cycles, max);
    end
    drv();
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    drv();
    drv();
    obs();
    checks++;
    if ({rinc, m_valid, busy, done, m_data, rd_total} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rinc=%b m_valid=%b busy=%b done=%b m_data=%h rd_total=%h, expected all 0",
               rinc, m_valid, busy, done, m_data, rd_total);
    end
    drv();
    rrst = 1'b0;
    do_start(16'd0);
    obs();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start: got done=%b busy=%b, expected 1 1", done, busy);
    end
    drv();
    exp_total = 16'd0;
  endtask

  task automatic test_basic();
    logic [7:0] w[4];
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) load(w[i]);
    m_ready = 1'b1;
    do_start(16'd4);
    for (int i = 0; i < 7; i++) begin
      obs();
      checks++;
      if (rinc !== (i < 4)) begin
        errors++;
        $display("FAIL basic_rinc[%0d]: got %b, expected %b", i, rinc, (i < 4));
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== w[i-1]) begin
          errors++;
          $display("FAIL basic_data[%0d]: got valid=%b data=%h, expected 1 %h", i, m_valid, m_data, w[i-1]);
        end
      end
      checks++;
      if (done !== (i == 5) || busy !== (i < 6)) begin
        errors++;
        $display("FAIL basic_done[%0d]: got done=%b busy=%b, expected %b %b", i, done, busy, (i == 5), (i < 6));
      end
      drv();
    end
    exp_total = exp_total + 16'd4;
    checks++;
    if (rd_total !== exp_total || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_total: got rd_total=%h left=%0d, expected %h 0", rd_total, sb.size(), exp_total);
    end
  endtask

  task automatic test_zero_len();
    fifo_m.push_back(8'h5A);
    m_ready = 1'b1;
    drv();
    do_start(16'd0);
    obs();
    checks++;
    if (done !== 1'b1 || rinc !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b rinc=%b, expected 1 0", done, rinc);
    end
    drv();
    obs();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rinc !== 1'b0 || rd_total !== exp_total) begin
      errors++;
      $display("FAIL zero_after: got done=%b busy=%b rinc=%b rd_total=%h, expected 0 0 0 %h",
               done, busy, rinc, rd_total, exp_total);
    end
    drv();
    fifo_m.delete();
  endtask

  task automatic test_backpressure();
    int n;
    int c;
    for (int i = 0; i < 5; i++) load(8'hA1 + 8'(i));
    m_ready = 1'b0;
    do_start(16'd5);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      obs();
      if (rinc) n++;
      if (i >= 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA1) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got valid=%b data=%h, expected 1 a1", i, m_valid, m_data);
        end
      end
      drv();
      start     = (i == 2);
      burst_len = 16'd9;
    end
    start     = 1'b0;
    burst_len = 16'd0;
    obs();
    checks++;
    if (n != 2 || rinc !== 1'b0) begin
      errors++;
      $display("FAIL bp_pops: got %0d pops rinc=%b, expected 2 0", n, rinc);
    end
    drv();
    m_ready = 1'b1;
    wait_done(20, c);
    exp_total = exp_total + 16'd5;
    obs();
    checks++;
    if (sb.size() != 0 || rd_total !== exp_total || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got left=%0d rd_total=%h busy=%b, expected 0 %h 0", sb.size(), rd_total, busy, exp_total);
    end
    drv();
  endtask

  task automatic test_rempty_toggle();
    int c;
    for (int i = 0; i < 6; i++) load(8'hB0 + 8'(i));
    m_ready   = 1'b1;
    toggle_en = 1'b1;
    do_start(16'd6);
    wait_done(40, c);
    toggle_en   = 1'b0;
    force_empty = 1'b0;
    exp_total   = exp_total + 16'd6;
    checks++;
    if (sb.size() != 0 || rd_total !== exp_total) begin
      errors++;
      $display("FAIL toggle_end: got left=%0d rd_total=%h, expected 0 %h", sb.size(), rd_total, exp_total);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i));
    m_ready = 1'b0;
    do_start(16'd4);
    drv();
    drv();
    obs();
    checks++;
    if (m_valid !== 1'b1 || rinc !== 1'b0 || m_data !== 8'hC0) begin
      errors++;
      $display("FAIL rstmid_full: got valid=%b rinc=%b data=%h, expected 1 0 c0", m_valid, rinc, m_data);
    end
    drv();
    m_ready = 1'b1;
    rrst    = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || rinc !== 1'b0 || rd_total !== 16'd0 || busy !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_clear: got valid=%b rinc=%b rd_total=%h busy=%b data=%h, expected 0 0 0000 0 00",
               m_valid, rinc, rd_total, busy, m_data);
    end
    sb.delete();
    fifo_m.delete();
    m_ready = 1'b0;
    drv();
    drv();
    rrst      = 1'b0;
    exp_total = 16'd0;
    drv();
  endtask

  task automatic test_wrap();
    int c;
    inf_src     = 1'b1;
    sb_en       = 1'b0;
    force_empty = 1'b0;
    m_ready     = 1'b1;
    drv();
    do_start(16'd32767);
    wait_done(32800, c);
    checks++;
    if (c != 32769) begin
      errors++;
      $display("FAIL wrap_rate: got done after %0d cycles, expected 32769", c);
    end
    do_start(16'd32767);
    wait_done(32800, c);
    checks++;
    if (rd_total !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_fffe: got rd_total=%h, expected fffe", rd_total);
    end
    do_start(16'd3);
    wait_done(10, c);
    checks++;
    if (rd_total !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_0001: got rd_total=%h, expected 0001", rd_total);
    end
    inf_src = 1'b0;
    sb_en   = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rrst        = 1'b1;
    start       = 1'b0;
    burst_len   = 16'd0;
    m_ready     = 1'b0;
    rempty      = 1'b1;
    rdata       = 8'h00;
    pop_prev    = 1'b0;
    force_empty = 1'b0;
    toggle_en   = 1'b0;
    inf_src     = 1'b0;
    sb_en       = 1'b1;
    exp_total   = 16'd0;

    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_rempty_toggle();
    test_reset_mid();
    test_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
